// File: rtl/password_memory.sv
// Password store: combinational XOR-keyed ROM plus a 256-word RAM copy that is
// preloaded from the ROM after every reset. Both memories share one address bus.
module password_memory #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 16,
  parameter int                RAM_AW  = 8,
  parameter logic [DATA_W-1:0] ROM_KEY = 16'h5A5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] _Address,
  input  logic [DATA_W-1:0] _Data_In,
  input  logic              wren,
  output logic [DATA_W-1:0] _Data,
  output logic [DATA_W-1:0] _Data_Out,
  output logic              _Match,
  output logic              _Busy
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ROM content: byte-swapped address XOR key
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    rom_word = DATA_W'({a[7:0], a[15:8]}) ^ ROM_KEY;
  endfunction

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [DATA_W-1:0]   mem_q [RAM_DEPTH];

  logic                mem_we_s;
  logic [RAM_AW-1:0]   mem_idx_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [RAM_AW-1:0]   ram_idx_s;

  assign ram_idx_s = _Address[RAM_AW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    data_d      = data_q;
    data_out_d  = data_out_q;
    mem_we_s    = 1'b0;
    mem_idx_s   = ram_idx_s;
    mem_wdata_s = _Data_In;
    case (state_q)
      ST_LOAD: begin
        mem_we_s    = 1'b1;
        mem_idx_s   = cnt_q;
        mem_wdata_s = rom_word({{(ADDR_W-RAM_AW){1'b0}}, cnt_q});
        data_d      = '0;
        data_out_d  = '0;
        if (cnt_q == {RAM_AW{1'b1}}) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          busy_d  = 1'b1;
          cnt_d   = cnt_q + RAM_AW'(1);
        end
      end
      ST_RUN: begin
        busy_d     = 1'b0;
        mem_we_s   = wren;
        // Non-blocking read of mem_q yields the old word on a same-address write
        data_d     = rom_word(_Address);
        data_out_d = mem_q[ram_idx_s];
      end
      default: begin
        state_d = ST_LOAD;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      data_q     <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
    end
  end

  // RAM array has no reset; it is rebuilt by the preload instead
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

  assign _Data     = data_q;
  assign _Data_Out = data_out_q;
  assign _Busy     = busy_q;
  assign _Match    = (data_q == data_out_q) && !busy_q;

endmodule

// File: tb/tb_password_memory.sv
// Directed self-checking bench for password_memory: preload, read sweep,
// read-before-write, RAM aliasing and reset during preload.
module tb_password_memory;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] din;
  logic        wren;
  logic [15:0] data;
  logic [15:0] dout;
  logic        match;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  password_memory dut (
    .clk       (clk),
    .reset     (reset),
    ._Address  (addr),
    ._Data_In  (din),
    .wren      (wren),
    ._Data     (data),
    ._Data_Out (dout),
    ._Match    (match),
    ._Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ROM: {a[7:0], a[15:8]} ^ 16'h5A5A
  function automatic logic [15:0] ref_rom(input logic [15:0] a);
    logic [15:0] swapped;
    swapped = {a[7:0], a[15:8]};
    return swapped ^ 16'h5A5A;
  endfunction

  task automatic run_preload();
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i < 256) begin
        check_eq("busy_load", {15'd0, busy}, 16'd1);
        check_eq("data_load", data, 16'h0000);
        check_eq("dout_load", dout, 16'h0000);
        check_eq("match_load", {15'd0, match}, 16'd0);
      end else begin
        check_eq("busy_done", {15'd0, busy}, 16'd0);
      end
    end
  endtask

  task automatic run_sweep();
    wren = 1'b0;
    for (int a = 0; a < 256; a++) begin
      addr = 16'(a);
      step();
      check_eq("sweep_data", data, ref_rom(16'(a)));
      check_eq("sweep_dout", dout, ref_rom(16'(a)));
      check_eq("sweep_match", {15'd0, match}, 16'd1);
      if (a == 1) check_eq("rom_0001", data, 16'h5B5A);
    end
  endtask

  initial begin
    reset = 1'b1;
    addr  = 16'h0000;
    din   = 16'h0000;
    wren  = 1'b0;

    // Test 1: reset state and full preload
    step();
    check_eq("rst_busy", {15'd0, busy}, 16'd1);
    check_eq("rst_data", data, 16'h0000);
    check_eq("rst_dout", dout, 16'h0000);
    check_eq("rst_match", {15'd0, match}, 16'd0);
    reset = 1'b0;
    run_preload();

    // Test 2: every RAM word matches the ROM
    run_sweep();

    // Test 3: constant address gives constant data
    addr = 16'h1476;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_data", data, 16'h2C4E);
      check_eq("hold_dout", dout, 16'h2C5A);
      check_eq("hold_match", {15'd0, match}, 16'd0);
    end

    // Test 4: read-before-write on the same address
    addr = 16'h0010;
    din  = 16'hAAAA;
    wren = 1'b1;
    step();
    check_eq("rbw_old", dout, 16'h4A5A);
    check_eq("rbw_data", data, 16'h4A5A);
    check_eq("rbw_match", {15'd0, match}, 16'd1);
    wren = 1'b0;
    step();
    check_eq("rbw_new", dout, 16'hAAAA);
    check_eq("rbw_nomatch", {15'd0, match}, 16'd0);

    // Test 5: upper address bits alias onto the same RAM word
    addr = 16'h0110;
    din  = 16'hBEEF;
    wren = 1'b1;
    step();
    check_eq("alias_old", dout, 16'hAAAA);
    check_eq("alias_rom", data, 16'h4A5B);
    wren = 1'b0;
    addr = 16'h0010;
    step();
    check_eq("alias_dout", dout, 16'hBEEF);
    check_eq("alias_data", data, 16'h4A5A);
    check_eq("alias_match", {15'd0, match}, 16'd0);

    // Test 6: reset mid-preload with writes attempted while busy
    reset = 1'b1;
    step();
    reset = 1'b0;
    wren  = 1'b1;
    din   = 16'hDEAD;
    addr  = 16'h0010;
    for (int i = 0; i < 100; i++) begin
      addr = 16'(i);
      step();
    end
    check_eq("mid_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    step();
    check_eq("rst2_busy", {15'd0, busy}, 16'd1);
    check_eq("rst2_data", data, 16'h0000);
    check_eq("rst2_dout", dout, 16'h0000);
    reset = 1'b0;
    addr  = 16'h0010;
    run_preload();
    run_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
